// File: rtl/corr_dump_pkg.sv
// corr_dump_pkg: shared types and width helpers for the
// correlator arm-and-dump controller.
package corr_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ACCUM = 2'd2,
    ST_READY = 2'd3
  } state_e;

  localparam int SUM_EXT = 8;

  function automatic int sum_w(input int acc_w);
    return acc_w + SUM_EXT;
  endfunction

endpackage

// File: rtl/corr_sum_acc.sv
// corr_sum_acc: signed running sum of sign-extended
// accumulator dumps, with synchronous clear and enable.
module corr_sum_acc #(
  parameter int ACC_W = 24,
  parameter int SUM_W = 32
) (
  input  logic                    dclk,
  input  logic                    reset_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [SUM_W-1:0] o_sum
);

  logic signed [SUM_W-1:0] r_sum;
  logic signed [SUM_W-1:0] w_ext;

  assign w_ext = {{(SUM_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
  assign o_sum = r_sum;

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + w_ext;
    end
  end

endmodule

// File: rtl/corr_dump_arm.sv
// corr_dump_arm: arms on the synchronised flag, aligns to an
// epoch, sums n_epoch I/Q dumps and hands them to the host.
module corr_dump_arm
  import corr_dump_pkg::*;
#(
  parameter  int ACC_W = 24,
  localparam int SUM_W = sum_w(ACC_W)
) (
  input  logic                    dclk,
  input  logic                    reset_n,
  input  logic                    flag,
  output logic                    rst_pulse,
  input  logic                    abort,
  input  logic [7:0]              n_epoch,
  input  logic                    epoch,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [ACC_W-1:0] acc_q,
  output logic signed [SUM_W-1:0] sum_i,
  output logic signed [SUM_W-1:0] sum_q,
  output logic                    ready,
  input  logic                    ack,
  output logic                    busy,
  output logic                    overrun,
  output logic [8:0]              epoch_cnt
);

  state_e     r_state;
  logic [8:0] r_cnt;
  logic [8:0] r_nlat;
  logic       r_rst_pulse;
  logic       r_ready;
  logic       r_busy;
  logic       r_ovr;

  logic       w_arm;
  logic       w_acc;
  logic [8:0] w_cnt_nxt;
  logic [8:0] w_nlat;

  logic signed [SUM_W-1:0] w_sum_i;
  logic signed [SUM_W-1:0] w_sum_q;

  assign w_arm     = (r_state == ST_IDLE) & flag & ~abort;
  assign w_acc     = (r_state == ST_ACCUM) & epoch & ~abort;
  assign w_cnt_nxt = r_cnt + 9'd1;
  assign w_nlat    = (n_epoch == 8'd0) ? 9'd256
                                       : {1'b0, n_epoch};

  always_ff @(posedge dclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_nlat      <= '0;
      r_rst_pulse <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_rst_pulse <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_ready <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (flag) begin
              r_state     <= ST_ARMED;
              r_rst_pulse <= 1'b1;
              r_cnt       <= '0;
              r_ovr       <= 1'b0;
              r_nlat      <= w_nlat;
              r_busy      <= 1'b1;
            end
          end
          // first epoch after arm closes a partial interval
          ST_ARMED: begin
            if (epoch) r_state <= ST_ACCUM;
          end
          ST_ACCUM: begin
            if (epoch) begin
              r_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == r_nlat) begin
                r_state <= ST_READY;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_READY: begin
            if (epoch) r_ovr <= 1'b1;
            if (ack) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  corr_sum_acc #(
    .ACC_W (ACC_W),
    .SUM_W (SUM_W)
  ) u_acc_i (
    .dclk    (dclk),
    .reset_n (reset_n),
    .i_clr   (w_arm),
    .i_en    (w_acc),
    .i_acc   (acc_i),
    .o_sum   (w_sum_i)
  );

  corr_sum_acc #(
    .ACC_W (ACC_W),
    .SUM_W (SUM_W)
  ) u_acc_q (
    .dclk    (dclk),
    .reset_n (reset_n),
    .i_clr   (w_arm),
    .i_en    (w_acc),
    .i_acc   (acc_q),
    .o_sum   (w_sum_q)
  );

  assign sum_i     = w_sum_i;
  assign sum_q     = w_sum_q;
  assign rst_pulse = r_rst_pulse;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign overrun   = r_ovr;
  assign epoch_cnt = r_cnt;

endmodule

// File: tb/tb_corr_dump_arm.sv
// tb_corr_dump_arm: directed and randomized checks of the
// arm/align/sum/handshake behaviour against a behavioural model.
module tb_corr_dump_arm;

  logic               dclk = 1'b0;
  logic               reset_n = 1'b0;
  logic               flag = 1'b0;
  logic               abort = 1'b0;
  logic               epoch = 1'b0;
  logic               ack = 1'b0;
  logic [7:0]         n_epoch = 8'd0;
  logic signed [23:0] acc_i = '0;
  logic signed [23:0] acc_q = '0;
  logic               rst_pulse;
  logic               ready;
  logic               busy;
  logic               overrun;
  logic [8:0]         epoch_cnt;
  logic signed [31:0] sum_i;
  logic signed [31:0] sum_q;

  always #5 dclk = ~dclk;

  corr_dump_arm #(.ACC_W(24)) dut (
    .dclk      (dclk),
    .reset_n   (reset_n),
    .flag      (flag),
    .rst_pulse (rst_pulse),
    .abort     (abort),
    .n_epoch   (n_epoch),
    .epoch     (epoch),
    .acc_i     (acc_i),
    .acc_q     (acc_q),
    .sum_i     (sum_i),
    .sum_q     (sum_q),
    .ready     (ready),
    .ack       (ack),
    .busy      (busy),
    .overrun   (overrun),
    .epoch_cnt (epoch_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: phase 0 idle, 1 waiting for alignment,
  // 2 summing, 3 holding results for the host
  int     m_phase;
  bit     m_pulse, m_busy, m_ready, m_ovr;
  int     m_cnt, m_nlat;
  longint m_si, m_sq;

  task automatic m_reset();
    m_phase = 0; m_pulse = 0; m_busy = 0; m_ready = 0;
    m_ovr = 0; m_cnt = 0; m_nlat = 0; m_si = 0; m_sq = 0;
  endtask

  task automatic m_step(input bit f, input bit ab, input bit ep,
                        input bit ak, input int ai, input int aq);
    m_pulse = 0;
    if (ab) begin
      m_phase = 0; m_ready = 0; m_busy = 0;
    end else if (m_phase == 0) begin
      if (f) begin
        m_phase = 1; m_pulse = 1; m_busy = 1;
        m_si = 0; m_sq = 0; m_cnt = 0; m_ovr = 0;
        m_nlat = (n_epoch == 0) ? 256 : int'(n_epoch);
      end
    end else if (m_phase == 1) begin
      if (ep) m_phase = 2;
    end else if (m_phase == 2) begin
      if (ep) begin
        m_si += ai; m_sq += aq; m_cnt++;
        if (m_cnt == m_nlat) begin
          m_phase = 3; m_ready = 1; m_busy = 0;
        end
      end
    end else begin
      if (ep) m_ovr = 1;
      if (ak) begin
        m_phase = 0; m_ready = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rst_pulse"}, 64'(rst_pulse), 64'(m_pulse));
    chk({tag, ".busy"}, 64'(busy), 64'(m_busy));
    chk({tag, ".ready"}, 64'(ready), 64'(m_ready));
    chk({tag, ".overrun"}, 64'(overrun), 64'(m_ovr));
    chk({tag, ".epoch_cnt"}, 64'(epoch_cnt), 64'(m_cnt));
    chk({tag, ".sum_i"}, 64'(sum_i), 64'(m_si));
    chk({tag, ".sum_q"}, 64'(sum_q), 64'(m_sq));
  endtask

  task automatic cyc(input string tag, input bit f, input bit ab,
                     input bit ep, input bit ak,
                     input int ai = 0, input int aq = 0);
    @(negedge dclk);
    flag = f; abort = ab; epoch = ep; ack = ak;
    acc_i = 24'(ai); acc_q = 24'(aq);
    m_step(f, ab, ep, ak, ai, aq);
    @(posedge dclk);
    #1;
    chk_all(tag);
  endtask

  function automatic int racc();
    return int'($urandom_range(0, 16777215)) - 8388608;
  endfunction

  initial begin
    m_reset();
    #3;
    chk_all("reset");
    @(negedge dclk);
    reset_n = 1'b1;
    cyc("idle", 0, 0, 1, 0, 5, 5);

    // nominal: flag lingers two cycles, first epoch is alignment
    n_epoch = 8'd4;
    cyc("nom.arm", 1, 0, 0, 0);
    cyc("nom.hold", 1, 0, 0, 0);
    cyc("nom.hold", 1, 0, 0, 0);
    cyc("nom.gap", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("nom.ep", 0, 0, 1, 0, 100, -50);
      cyc("nom.gap", 0, 0, 0, 0);
    end
    chk("nom.ready", 64'(ready), 64'(1));
    chk("nom.sum_i", 64'(sum_i), 64'(400));
    chk("nom.sum_q", 64'(sum_q), 64'(-200));
    chk("nom.cnt", 64'(epoch_cnt), 64'(4));
    cyc("nom.ack", 0, 0, 0, 1);

    // extremes: 256 back-to-back epochs at full scale
    n_epoch = 8'd0;
    cyc("ext.arm", 1, 0, 0, 0);
    for (int i = 0; i < 257; i++)
      cyc("ext.ep", 0, 0, 1, 0, -8388608, 8388607);
    chk("ext.sum_i", 64'(sum_i), 64'(-64'sd2147483648));
    chk("ext.sum_q", 64'(sum_q), 64'(64'sd2147483392));
    chk("ext.cnt", 64'(epoch_cnt), 64'(256));
    cyc("ext.ack", 0, 0, 0, 1);

    // overrun: three lost epochs before ack
    n_epoch = 8'd2;
    cyc("ovr.arm", 1, 0, 0, 0);
    cyc("ovr.ep", 0, 0, 1, 0, 7, 8);
    cyc("ovr.ep", 0, 0, 1, 0, 3, -4);
    cyc("ovr.ep", 0, 0, 1, 0, 5, 6);
    for (int i = 0; i < 3; i++)
      cyc("ovr.lost", 0, 0, 1, 0, 999, 999);
    chk("ovr.flag", 64'(overrun), 64'(1));
    chk("ovr.sum_i", 64'(sum_i), 64'(8));
    chk("ovr.sum_q", 64'(sum_q), 64'(2));
    cyc("ovr.ack", 0, 0, 0, 1);
    cyc("ovr.idle", 0, 0, 0, 0);
    cyc("ovr.rearm", 1, 0, 0, 0);
    chk("ovr.clr", 64'(overrun), 64'(0));
    cyc("ovr.abort", 0, 1, 0, 0);

    // flag and epoch together in IDLE, then ack with epoch
    cyc("sim.arm", 1, 0, 1, 0, 10, 20);
    cyc("sim.align", 0, 0, 1, 0, 30, 40);
    cyc("sim.ep", 0, 0, 1, 0, 1, 2);
    cyc("sim.ep", 0, 0, 1, 0, 3, 4);
    chk("sim.sum_i", 64'(sum_i), 64'(4));
    chk("sim.sum_q", 64'(sum_q), 64'(6));
    cyc("sim.ackep", 0, 0, 1, 1, 50, 50);
    chk("sim.ovr", 64'(overrun), 64'(1));
    chk("sim.ready", 64'(ready), 64'(0));

    // abort after 2 of 8 epochs
    n_epoch = 8'd8;
    cyc("abt.arm", 1, 0, 0, 0);
    cyc("abt.align", 0, 0, 1, 0, 1, 1);
    cyc("abt.ep", 0, 0, 1, 0, 11, 12);
    cyc("abt.ep", 0, 0, 1, 0, 13, 14);
    cyc("abt.abort", 0, 1, 1, 1, 77, 77);
    chk("abt.busy", 64'(busy), 64'(0));
    chk("abt.cnt", 64'(epoch_cnt), 64'(2));
    for (int i = 0; i < 4; i++)
      cyc("abt.idle", 0, 0, 1, 0, 9, 9);
    cyc("abt.rearm", 1, 0, 0, 0);
    chk("abt.cnt0", 64'(epoch_cnt), 64'(0));
    for (int i = 0; i < 9; i++)
      cyc("abt.ep", 0, 0, 1, 0, racc(), racc());
    cyc("abt.ack", 0, 0, 0, 1);

    // randomized lengths, data, spacing and ack delay
    for (int it = 0; it < 8; it++) begin
      n_epoch = 8'($urandom_range(1, 6));
      cyc("rnd.arm", 1, 0, 0, 0);
      for (int c = 0; c < 60 && !m_ready; c++)
        cyc("rnd.run", 0, 0, 1'($urandom_range(0, 1)), 0,
            racc(), racc());
      chk("rnd.done", 64'(ready), 64'(1));
      for (int c = $urandom_range(0, 3); c > 0; c--)
        cyc("rnd.wait", 0, 0, 1'($urandom_range(0, 1)), 0,
            racc(), racc());
      cyc("rnd.ack", 0, 0, 0, 1);
    end

    // asynchronous reset while READY
    n_epoch = 8'd1;
    cyc("rst.arm", 1, 0, 0, 0);
    cyc("rst.align", 0, 0, 1, 0, 1, 1);
    cyc("rst.ep", 0, 0, 1, 0, 123, -321);
    chk("rst.ready", 64'(ready), 64'(1));
    @(negedge dclk);
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    chk_all("rst.async");
    @(negedge dclk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc("rst.idle", 0, 0, 1, 1, 55, 66);
    cyc("rst.arm", 1, 0, 0, 0);
    cyc("rst.align", 0, 0, 1, 0, 2, 2);
    cyc("rst.ep", 0, 0, 1, 0, -9, 9);
    cyc("rst.ack", 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/corr_dump_arm.md
# corr_dump_arm

Arm-and-dump controller in the correlator's `dclk` domain, directly downstream of the cross-domain arming-flag synchroniser.
- When the synchronised arm `flag` is seen, the block returns a one-cycle `rst_pulse` to clear that flag.
- It aligns to the next correlator epoch, then sums `n_epoch` consecutive per-epoch I/Q accumulator dumps.
- It presents the sums to the host through a ready/ack handshake.
- It reports lost epochs through a sticky `overrun` bit.

## Interface
Parameters:
- `ACC_W`, 24: width of the signed per-epoch accumulator inputs.
- `SUM_W`, `ACC_W+8`: width of the signed output sums. This is a fixed derivation and must not be overridden.

Ports:
- `dclk`  in  1  correlator clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flag`  in  1  synchronised arm level from the flag synchroniser.
- `rst_pulse`  out  1  one-cycle clear request back to the flag synchroniser.
- `abort`  in  1  one-cycle software abort.
- `n_epoch`  in  8  number of epochs to sum; 0 means 256; sampled at arm.
- `epoch`  in  1  one-cycle epoch strobe; `acc_i`/`acc_q` are valid in the same cycle.
- `acc_i`, `acc_q`  in  `ACC_W`  signed per-epoch accumulator dumps.
- `sum_i`, `sum_q`  out  `SUM_W`  signed sums; held stable while `ready`=1.
- `ready`  out  1  sums are valid and waiting for the host.
- `ack`  in  1  one-cycle host acknowledge.
- `busy`  out  1  high in ARMED and ACCUM.
- `overrun`  out  1  sticky lost-epoch indicator; cleared at the next arm.
- `epoch_cnt`  out  9  number of epochs summed so far.

## Operation
- The state machine has four states: IDLE, ARMED, ACCUM, READY. Every output is registered.
- Reset values: state IDLE; `sum_i`, `sum_q`, `epoch_cnt`, `ready`, `rst_pulse`, `busy` and `overrun` all 0.
- **IDLE**, with `flag`=1 and `abort`=0:
  - go to ARMED;
  - `rst_pulse`<=1 for exactly one cycle;
  - clear both sums, `epoch_cnt` and `overrun`;
  - latch `n_epoch` as `n_lat` (9 bits; 0 maps to 256).
  - `epoch` is ignored in that cycle.
- **ARMED**: the first `epoch` is an alignment boundary only, because its dump covers a partial interval. Go to ACCUM without summing. `flag` is ignored; it may still be high for a couple of cycles until the synchroniser clears it.
- **ACCUM**, on each `epoch`:
  - sum <= sum + sign-extended acc (both channels);
  - `epoch_cnt`++.
  - When the increment makes `epoch_cnt`==`n_lat`, go to READY and set `ready`<=1 in the same edge.
- **READY**:
  - sums and `epoch_cnt` are frozen;
  - any `epoch` sets `overrun`<=1 (that data is lost);
  - `ack` sets `ready`<=0 and returns to IDLE;
  - `ack` in any other state is ignored.
- **abort**: from any state, go to IDLE with `ready`<=0. Sums and `epoch_cnt` keep their last values. No `rst_pulse` is issued.
- Simultaneous events:
  - `abort` wins over `ack`, arm and `epoch`.
  - `ack` together with `epoch` in READY: return to IDLE and also set `overrun`.
  - `flag` still high when re-entering IDLE: it re-arms on the next cycle. This is legal; the host must not leave `flag` pending.
- Width rule: `SUM_W`=`ACC_W`+8 holds 256 worst-case terms, so no overflow handling is required.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

## Timing
- Arm: if `flag` is sampled high at edge k, `rst_pulse` is high from k to k+1 and `busy`=1 from k.
- Epoch: a strobe at edge e updates the sums and `epoch_cnt` visibly after e.
- Completion: the last epoch at edge e gives `ready`=1 and final sums after e, with no extra pipeline stage.
- Ack: `ack` sampled at edge a gives `ready`=0 after a. The earliest re-arm is edge a+1.
- Minimum epoch spacing: 1 cycle. Back-to-back strobes each accumulate.

## Structure
- Package `corr_dump_pkg`:
  - state enum (IDLE, ARMED, ACCUM, READY);
  - constant `SUM_EXT`=8;
  - function `sum_w(acc_w)`.
- Sub-module `corr_sum_acc`: signed accumulator with clear and enable, instantiated twice (I and Q).
- The top level holds the FSM, the counter, the `n_lat` latch and the handshake/overrun logic.

## Test plan
- Nominal sum: `ACC_W`=24, `n_epoch`=4, `acc_i`=100, `acc_q`=-50 on every epoch → `rst_pulse` is one cycle wide and the first epoch is skipped. After 5 strobes: `ready`=1, `sum_i`=400, `sum_q`=-200, `epoch_cnt`=4.
- Extremes with `n_epoch`=0 (256 epochs):
  - `acc_i`=-2^23 on every epoch → `sum_i`=-2^31;
  - `acc_q`=2^23-1 on every epoch → `sum_q`=256·(2^23-1).
  - No wrap on either channel.
- Overrun: epoch strobes continue while READY and `ack` is delayed 3 epochs → `overrun`=1 and sums unchanged. `ack` → IDLE; `overrun` clears on the next arm.
- Simultaneous: `flag` and `epoch` in the same IDLE cycle → the epoch is not counted and the next epoch is still the alignment boundary. In a separate sequence, `ack` and `epoch` in the same READY cycle → IDLE with `overrun`=1.
- Abort: `abort` in ACCUM after 2 of 8 epochs → IDLE, `ready` never asserted, `busy`=0, no `rst_pulse`. The next `flag` arms cleanly with `epoch_cnt`=0.
- Reset: `reset_n` pulsed low in READY → all outputs at their reset values at once; the block stays idle until `flag`.
